keypad_scanner: RTL

Parametrised matrix-keypad scanner, debouncer and key decoder. It drives one-hot column strobes, synchronises and debounces the row returns, and locks onto the first key found. It emits one key code per physical press and keeps a two-entry key history for the dual seven-segment display path. It sits between the keypad pins and the display multiplexer and replaces purely combinational row/column decoding.

---
 rtl/keypad_scanner.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Matrix-keypad scanner, debouncer and key decoder. Drives one-hot column
//   strobes, synchronises and debounces the row returns, locks onto the first
//   key it sees and reports one code per physical press. A two-entry history
//   (digit_new / digit_old) feeds the dual seven-segment display path.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high; clears all state
//   rows       in   [NUM_ROWS] raw row returns, active-high, asynchronous
//   cols       out  [NUM_COLS] one-hot column strobe, active-high
//   key_code   out  [CODE_W]   code of the currently / most recently locked key
//   key_valid  out  one-cycle pulse on each accepted press
//   key_held   out  high while a key is locked (HELD or RELEASE)
//   digit_new  out  [CODE_W]   newest accepted key
//   digit_old  out  [CODE_W]   previous accepted key
//   dbg_state  out  [2]        current FSM state (SCAN=0, DEBOUNCE=1, HELD=2, RELEASE=3)
//
// Output protocol: key_valid is a pure strobe with no back-pressure. key_code,
// digit_new and digit_old are updated on the same edge that raises key_valid
// and are stable for at least that whole cycle.

module keypad_scanner #(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int HEX_MAP         = 1,
    localparam int CODE_W = ($clog2(NUM_ROWS * NUM_COLS) > 1) ? $clog2(NUM_ROWS * NUM_COLS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] cols,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held,
    output logic [CODE_W-1:0]   digit_new,
    output logic [CODE_W-1:0]   digit_old,
    output logic [1:0]          dbg_state
);

    localparam int ROW_W = ($clog2(NUM_ROWS) > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int COL_W = ($clog2(NUM_COLS) > 1) ? $clog2(NUM_COLS) : 1;
    localparam int DIV_W = ($clog2(SCAN_DIV) > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam bit USE_HEX = (HEX_MAP == 1) && (NUM_ROWS == 4) && (NUM_COLS == 4);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [NUM_ROWS-1:0] r_sync1;
    logic [NUM_ROWS-1:0] r_rows_s;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [DIV_W-1:0]    r_div;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_COLS-1:0] r_cols;
    logic [CODE_W-1:0]   r_key_code;
    logic [CODE_W-1:0]   r_digit_new;
    logic [CODE_W-1:0]   r_digit_old;
    logic                r_key_valid;
    logic                r_key_held;

    logic                w_any_row;
    logic                w_locked;
    logic                w_div_last;
    logic                w_cnt_done;
    logic [ROW_W-1:0]    w_low_row;
    logic [COL_W-1:0]    w_next_col;
    logic [NUM_COLS-1:0] w_next_cols;
    logic [CODE_W-1:0]   w_code;

    // Hex legend: rows top to bottom 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
    // The linear index r*NUM_COLS+c selects the legend entry.
    function automatic logic [CODE_W-1:0] make_code(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        int         lin;
        logic [3:0] h;
        lin = int'(r) * NUM_COLS + int'(c);
        h   = 4'h0;
        case (lin)
            0:  h = 4'h1;
            1:  h = 4'h2;
            2:  h = 4'h3;
            3:  h = 4'hA;
            4:  h = 4'h4;
            5:  h = 4'h5;
            6:  h = 4'h6;
            7:  h = 4'hB;
            8:  h = 4'h7;
            9:  h = 4'h8;
            10: h = 4'h9;
            11: h = 4'hC;
            12: h = 4'hE;
            13: h = 4'h0;
            14: h = 4'hF;
            15: h = 4'hD;
            default: h = 4'h0;
        endcase
        if (USE_HEX) make_code = CODE_W'(h);
        else         make_code = CODE_W'(lin);
    endfunction

    // Lowest-index asserted row wins when several rows are active at once.
    always_comb begin
        w_low_row = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (r_rows_s[i]) w_low_row = ROW_W'(i);
        end
    end

    assign w_any_row   = |r_rows_s;
    assign w_locked    = r_rows_s[r_row];
    assign w_div_last  = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_cnt_done  = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign w_next_col  = (r_col == COL_W'(NUM_COLS - 1)) ? '0 : r_col + COL_W'(1);
    assign w_next_cols = NUM_COLS'(1) << w_next_col;
    assign w_code      = make_code(r_row, r_col);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_SCAN;
            r_sync1     <= '0;
            r_rows_s    <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_cols      <= NUM_COLS'(1);
            r_key_code  <= '0;
            r_digit_new <= '0;
            r_digit_old <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_sync1     <= rows;
            r_rows_s    <= r_sync1;
            r_key_valid <= 1'b0;

            case (r_state)
                S_SCAN: begin
                    // Sample only on the last cycle of a column period so the
                    // synchroniser has caught up with the current strobe.
                    if (w_div_last) begin
                        r_div <= '0;
                        if (w_any_row) begin
                            r_row   <= w_low_row;
                            r_cnt   <= '0;
                            r_state <= S_DEBOUNCE;
                        end else begin
                            r_col  <= w_next_col;
                            r_cols <= w_next_cols;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end

                S_DEBOUNCE: begin
                    if (!w_locked) begin
                        // Glitch: abandon this key and move on to the next column.
                        r_state <= S_SCAN;
                        r_col   <= w_next_col;
                        r_cols  <= w_next_cols;
                        r_div   <= '0;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state     <= S_HELD;
                        r_cnt       <= '0;
                        r_key_code  <= w_code;
                        r_digit_old <= r_digit_new;
                        r_digit_new <= w_code;
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_HELD: begin
                    if (!w_locked) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= '0;
                    end
                end

                S_RELEASE: begin
                    if (w_locked) begin
                        // Release bounce: the same press, so no new key_valid.
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state    <= S_SCAN;
                        r_col      <= w_next_col;
                        r_cols     <= w_next_cols;
                        r_div      <= '0;
                        r_cnt      <= '0;
                        r_key_held <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: r_state <= S_SCAN;
            endcase
        end
    end

    assign cols      = r_cols;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign digit_new = r_digit_new;
    assign digit_old = r_digit_old;
    assign dbg_state = r_state;

endmodule
